// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and geometry helpers for the instruction-fetch front end.
// The widths of the PC fields are derived from the PC, line and cache-depth
// parameters. The cache module and the top module both use these helpers, so
// the two always agree on where offset, index and tag sit inside a PC.
//   state_t          : refill controller state (IDLE lookup / REFILL pending)
//   offsetWidth()    : byte-offset bits inside one cache line
//   indexWidth()     : line-select bits
//   tagWidth()       : remaining upper PC bits stored as the tag
//   wordsPerLine()   : instructions held by one line
//   byteSelWidth()   : byte-address bits inside one instruction
// -----------------------------------------------------------------------------
package fetch_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    REFILL = 1'b1
  } state_t;

  function automatic int offsetWidth(input int lineW);
    return $clog2(lineW / 8);
  endfunction

  function automatic int indexWidth(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tagWidth(input int pcW, input int lineW, input int lines);
    return pcW - offsetWidth(lineW) - indexWidth(lines);
  endfunction

  function automatic int wordsPerLine(input int lineW, input int insW);
    return lineW / insW;
  endfunction

  function automatic int byteSelWidth(input int insW);
    return $clog2(insW / 8);
  endfunction

endpackage

// File: rtl/fetch_icache.sv
// -----------------------------------------------------------------------------
// fetch_icache
// Direct-mapped instruction cache storage. It holds one valid bit, one tag and
// one data line per entry.
// Reads are purely combinational, so a hit is visible in the same cycle as the
// PC that looks it up. Writes happen on the clock edge.
//   clk, rst_n     : clock, asynchronous active-low reset (clears valid bits)
//   i_rd_pc        : lookup PC
//   o_hit          : entry valid and tag matches
//   o_word         : instruction selected from the indexed line
//   i_wr_en        : write the line/tag at i_wr_index this edge
//   i_wr_index     : line to write
//   i_wr_tag       : tag to store
//   i_wr_line      : line data, word 0 in the LSBs
//   i_invalidate   : clear every valid bit this edge
// -----------------------------------------------------------------------------
module fetch_icache
  import fetch_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int INS_W  = 16,
  parameter int LINE_W = 64,
  parameter int LINES  = 8
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [PC_W-1:0]                         i_rd_pc,
  output logic                                    o_hit,
  output logic [INS_W-1:0]                        o_word,
  input  logic                                    i_wr_en,
  input  logic [indexWidth(LINES)-1:0]            i_wr_index,
  input  logic [tagWidth(PC_W, LINE_W, LINES)-1:0] i_wr_tag,
  input  logic [LINE_W-1:0]                       i_wr_line,
  input  logic                                    i_invalidate
);

  localparam int OFF_W  = offsetWidth(LINE_W);
  localparam int IDX_W  = indexWidth(LINES);
  localparam int TAG_W  = tagWidth(PC_W, LINE_W, LINES);
  localparam int BYTE_W = byteSelWidth(INS_W);

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [LINE_W-1:0] r_data [LINES];

  logic [OFF_W-1:0]  w_offset;
  logic [IDX_W-1:0]  w_index;
  logic [TAG_W-1:0]  w_tag;
  logic [31:0]       w_wordSel;
  logic [LINE_W-1:0] w_shifted;

  assign w_offset  = i_rd_pc[OFF_W-1:0];
  assign w_index   = i_rd_pc[OFF_W +: IDX_W];
  assign w_tag     = i_rd_pc[PC_W-1 -: TAG_W];

  // Byte offset converted to a word number; word 0 sits at the line LSBs,
  // so shifting right by whole words brings the wanted one to the bottom.
  assign w_wordSel = 32'(w_offset) >> BYTE_W;
  assign w_shifted = r_data[w_index] >> (w_wordSel * INS_W);

  assign o_word = w_shifted[INS_W-1:0];
  assign o_hit  = r_valid[w_index] && (r_tag[w_index] == w_tag);

  // Invalidate beats a fill on the same edge. The fill still stores its data
  // and tag below, but the entry is left invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_invalidate) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  // Tag and data need no reset; they are only trusted through the valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_line;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. It contains the PC register, a direct-mapped
// instruction cache and a single-request refill state machine. It presents
// instructions to decode through a valid/stall handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   i_redirect        : load i_redirect_pc; squashes this cycle's instruction
//   i_redirect_pc     : redirect target (instruction aligned)
//   i_stall           : decode cannot accept; PC holds
//   i_invalidate      : clear all cache valid bits
//   o_ins_valid       : o_ins/o_pc_out carry a fetched instruction
//   o_ins             : instruction at o_pc_out, zero when not valid
//   o_pc_out          : current PC
//   o_pc_inc          : o_pc_out plus one instruction, wrapping
//   o_mem_req         : line refill request, held until i_mem_ack
//   o_mem_addr        : line-aligned refill address
//   i_mem_ack         : refill data present this cycle
//   i_mem_data        : refill line
// -----------------------------------------------------------------------------
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INS_W    = 16,
  parameter int              LINE_W   = 64,
  parameter int              LINES    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_redirect,
  input  logic [PC_W-1:0]   i_redirect_pc,
  input  logic              i_stall,
  input  logic              i_invalidate,
  output logic              o_ins_valid,
  output logic [INS_W-1:0]  o_ins,
  output logic [PC_W-1:0]   o_pc_out,
  output logic [PC_W-1:0]   o_pc_inc,
  output logic              o_mem_req,
  output logic [PC_W-1:0]   o_mem_addr,
  input  logic              i_mem_ack,
  input  logic [LINE_W-1:0] i_mem_data
);

  localparam int OFF_W = offsetWidth(LINE_W);
  localparam int IDX_W = indexWidth(LINES);
  localparam int TAG_W = tagWidth(PC_W, LINE_W, LINES);

  state_t          r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_memReq;
  logic [PC_W-1:0] r_memAddr;

  logic             w_hit;
  logic [INS_W-1:0] w_word;
  logic             w_insValid;
  logic             w_fill;
  logic [PC_W-1:0]  w_pcInc;

  fetch_icache #(
    .PC_W   (PC_W),
    .INS_W  (INS_W),
    .LINE_W (LINE_W),
    .LINES  (LINES)
  ) u_icache (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_rd_pc      (r_pc),
    .o_hit        (w_hit),
    .o_word       (w_word),
    .i_wr_en      (w_fill),
    .i_wr_index   (r_memAddr[OFF_W +: IDX_W]),
    .i_wr_tag     (r_memAddr[PC_W-1 -: TAG_W]),
    .i_wr_line    (i_mem_data),
    .i_invalidate (i_invalidate)
  );

  // An ack only counts while a request is outstanding, which is exactly the
  // REFILL state; stray acks in IDLE never touch the arrays.
  assign w_fill  = (r_state == REFILL) && i_mem_ack;
  assign w_pcInc = r_pc + PC_W'(INS_W / 8);

  // Lookups only happen in IDLE. A redirect squashes the instruction that
  // sits at the old PC, and an invalidate hides a hit that is about to vanish.
  assign w_insValid = (r_state == IDLE) && w_hit && !i_redirect && !i_invalidate;

  assign o_ins_valid = w_insValid;
  assign o_ins       = w_insValid ? w_word : '0;
  assign o_pc_out    = r_pc;
  assign o_pc_inc    = w_pcInc;
  assign o_mem_req   = r_memReq;
  assign o_mem_addr  = r_memAddr;

  // PC update and refill controller. The PC only advances when decode actually
  // took an instruction. A redirect is honoured in either state. A refill that
  // is already outstanding always completes, because the request cannot be
  // withdrawn once memory has seen it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_pc      <= RESET_PC;
      r_memReq  <= 1'b0;
      r_memAddr <= '0;
    end else begin
      if (i_redirect) begin
        r_pc <= i_redirect_pc;
      end else if (w_insValid && !i_stall) begin
        r_pc <= w_pcInc;
      end

      case (r_state)
        IDLE: begin
          if (!w_hit) begin
            r_state   <= REFILL;
            r_memReq  <= 1'b1;
            r_memAddr <= {r_pc[PC_W-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        REFILL: begin
          if (i_mem_ack) begin
            r_state  <= IDLE;
            r_memReq <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Bench for fetch_unit with PC_W=16, INS_W=16, LINE_W=64, LINES=8 and
// RESET_PC=0x0040. A behavioural memory answers refills after memLat request
// cycles. Every memory word is a fixed bijection of its byte address.
// Instructions that decode is expected to accept are queued up front. They are
// popped whenever the DUT shows ins_valid with stall low.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int          PC_W     = 16;
  localparam int          INS_W    = 16;
  localparam int          LINE_W   = 64;
  localparam int          LINES    = 8;
  localparam logic [15:0] RESET_PC = 16'h0040;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = '0;
  logic        stall = 1'b0;
  logic        invalidate = 1'b0;
  logic        insValid;
  logic [15:0] ins;
  logic [15:0] pcOut;
  logic [15:0] pcInc;
  logic        memReq;
  logic [15:0] memAddr;
  logic        memAck = 1'b0;
  logic [63:0] memData = '0;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] ins;
  } fetch_t;

  typedef struct {
    logic        st;
    logic        expValid;
    logic [15:0] expPc;
    logic [15:0] expIns;
    logic        expReq;
    logic [15:0] expAddr;
  } vec_t;

  fetch_t expQ[$];
  vec_t   vecs[18];

  int checks = 0;
  int failures = 0;
  int memLat = 3;
  int reqCount = 0;
  bit invalOnAck = 1'b0;
  bit spuriousAck = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W     (PC_W),
    .INS_W    (INS_W),
    .LINE_W   (LINE_W),
    .LINES    (LINES),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_redirect    (redirect),
    .i_redirect_pc (redirectPc),
    .i_stall       (stall),
    .i_invalidate  (invalidate),
    .o_ins_valid   (insValid),
    .o_ins         (ins),
    .o_pc_out      (pcOut),
    .o_pc_inc      (pcInc),
    .o_mem_req     (memReq),
    .o_mem_addr    (memAddr),
    .i_mem_ack     (memAck),
    .i_mem_data    (memData)
  );

  // Memory content: a bijection of the byte address, so every word is distinct.
  function automatic logic [15:0] memWord(input logic [15:0] a);
    return a ^ 16'hBEEF;
  endfunction

  function automatic logic [63:0] memLine(input logic [15:0] base);
    logic [63:0] l;
    for (int i = 0; i < 4; i++) l[16*i +: 16] = memWord(base + 16'(2 * i));
    return l;
  endfunction

  function automatic vec_t mk(input logic st, input logic v, input logic [15:0] pc,
                              input logic req, input logic [15:0] addr);
    vec_t r;
    r.st = st; r.expValid = v; r.expPc = pc;
    r.expIns = v ? memWord(pc) : 16'h0000;
    r.expReq = req; r.expAddr = addr;
    return r;
  endfunction

  task automatic pushExp(input logic [15:0] pc);
    fetch_t e;
    e.pc = pc;
    e.ins = memWord(pc);
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and run the memory model.
  // Then sample the outputs and retire accepted instructions into the scoreboard.
  task automatic applyStimulus(input logic rd, input logic [15:0] rpc,
                               input logic st, input logic inv);
    fetch_t e;
    @(negedge clk);
    redirect = rd; redirectPc = rpc; stall = st; invalidate = inv;
    memAck = 1'b0; memData = '0;
    if (spuriousAck) begin
      memAck = 1'b1;
      memData = 64'hDEAD_DEAD_DEAD_DEAD;
    end else if (memReq) begin
      reqCount++;
      if (reqCount >= memLat) begin
        memAck = 1'b1;
        memData = memLine(memAddr);
        reqCount = 0;
      end
    end else begin
      reqCount = 0;
    end
    if (memAck && invalOnAck) invalidate = 1'b1;
    #1;
    if (insValid && !stall) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL sb_unexpected: got fetch at pc 0x%0h, expected none", pcOut);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_pc", 32'(pcOut), 32'(e.pc));
        checkOutput("sb_ins", 32'(ins), 32'(e.ins));
      end
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    redirect = 1'b0; stall = 1'b0; invalidate = 1'b0;
    memAck = 1'b0; reqCount = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_pc", 32'(pcOut), 32'(RESET_PC));
    checkOutput("rst_req", 32'(memReq), 32'd0);
    checkOutput("rst_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_valid", 32'(insValid), 32'd0);
    checkOutput("rst_ins", 32'(ins), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Idle with stall high until a hit shows up. While the refill is pending,
  // check that its address is the expected line.
  task automatic waitValid(input int maxCycles, input logic [15:0] lineAddr);
    bit seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      if (insValid) seen = 1'b1;
      else if (memReq) checkOutput("refill_addr", 32'(memAddr), 32'(lineAddr));
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL wait_valid: got no hit in %0d cycles, expected line 0x%0h", maxCycles, lineAddr);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ackSeen;

    // Cold start at RESET_PC: 3-cycle refill, four hits, next-line miss,
    // second refill, then a 4-cycle stall on a hit before it is accepted.
    vecs[0]  = mk(1'b0, 1'b0, 16'h0040, 1'b0, 16'h0000);
    vecs[1]  = mk(1'b0, 1'b0, 16'h0040, 1'b1, 16'h0040);
    vecs[2]  = mk(1'b0, 1'b0, 16'h0040, 1'b1, 16'h0040);
    vecs[3]  = mk(1'b0, 1'b0, 16'h0040, 1'b1, 16'h0040);
    vecs[4]  = mk(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0040);
    vecs[5]  = mk(1'b0, 1'b1, 16'h0042, 1'b0, 16'h0040);
    vecs[6]  = mk(1'b0, 1'b1, 16'h0044, 1'b0, 16'h0040);
    vecs[7]  = mk(1'b0, 1'b1, 16'h0046, 1'b0, 16'h0040);
    vecs[8]  = mk(1'b0, 1'b0, 16'h0048, 1'b0, 16'h0040);
    vecs[9]  = mk(1'b0, 1'b0, 16'h0048, 1'b1, 16'h0048);
    vecs[10] = mk(1'b0, 1'b0, 16'h0048, 1'b1, 16'h0048);
    vecs[11] = mk(1'b0, 1'b0, 16'h0048, 1'b1, 16'h0048);
    vecs[12] = mk(1'b1, 1'b1, 16'h0048, 1'b0, 16'h0048);
    vecs[13] = mk(1'b1, 1'b1, 16'h0048, 1'b0, 16'h0048);
    vecs[14] = mk(1'b1, 1'b1, 16'h0048, 1'b0, 16'h0048);
    vecs[15] = mk(1'b1, 1'b1, 16'h0048, 1'b0, 16'h0048);
    vecs[16] = mk(1'b0, 1'b1, 16'h0048, 1'b0, 16'h0048);
    vecs[17] = mk(1'b0, 1'b1, 16'h004A, 1'b0, 16'h0048);
    pushExp(16'h0040); pushExp(16'h0042); pushExp(16'h0044);
    pushExp(16'h0046); pushExp(16'h0048); pushExp(16'h004A);

    memLat = 3;
    resetDut();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b0, 16'h0, vecs[i].st, 1'b0);
      checkOutput($sformatf("vec%0d_valid", i), 32'(insValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_pc", i), 32'(pcOut), 32'(vecs[i].expPc));
      checkOutput($sformatf("vec%0d_ins", i), 32'(ins), 32'(vecs[i].expIns));
      checkOutput($sformatf("vec%0d_req", i), 32'(memReq), 32'(vecs[i].expReq));
      checkOutput($sformatf("vec%0d_addr", i), 32'(memAddr), 32'(vecs[i].expAddr));
    end

    // Redirect while the 0x0040 refill is pending. 0x0108 is used because
    // 0x0100 shares index 0 with 0x0040 here and would evict it.
    resetDut();
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("rdr_c0_valid", 32'(insValid), 32'd0);
    applyStimulus(1'b1, 16'h0108, 1'b0, 1'b0);
    checkOutput("rdr_c1_req", 32'(memReq), 32'd1);
    checkOutput("rdr_c1_addr", 32'(memAddr), 32'h0040);
    checkOutput("rdr_c1_pc", 32'(pcOut), 32'h0040);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("rdr_c2_pc", 32'(pcOut), 32'h0108);
    checkOutput("rdr_c2_addr", 32'(memAddr), 32'h0040);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("rdr_c3_req", 32'(memReq), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("rdr_c4_valid", 32'(insValid), 32'd0);
    checkOutput("rdr_c4_pc", 32'(pcOut), 32'h0108);
    waitValid(20, 16'h0108);
    checkOutput("rdr_hit_ins", 32'(ins), 32'(memWord(16'h0108)));
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0);
    checkOutput("rdr_squash", 32'(insValid), 32'd0);
    pushExp(16'h0040);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    checkOutput("rdr_back_valid", 32'(insValid), 32'd1);
    checkOutput("rdr_back_pc", 32'(pcOut), 32'h0040);
    checkOutput("rdr_back_req", 32'(memReq), 32'd0);

    // Conflict: 0x0000 and 0x0040 share index 0 and keep evicting each other.
    applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
    checkOutput("cf_squash", 32'(insValid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("cf_miss0_valid", 32'(insValid), 32'd0);
    waitValid(20, 16'h0000);
    checkOutput("cf_hit0_ins", 32'(ins), 32'(memWord(16'h0000)));
    applyStimulus(1'b1, 16'h0040, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("cf_miss40_valid", 32'(insValid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("cf_miss40_addr", 32'(memAddr), 32'h0040);
    waitValid(20, 16'h0040);
    applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("cf_remiss0_valid", 32'(insValid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("cf_remiss0_req", 32'(memReq), 32'd1);
    checkOutput("cf_remiss0_addr", 32'(memAddr), 32'h0000);
    waitValid(20, 16'h0000);

    // Invalidate on the same edge as the ack: the line stays invalid.
    applyStimulus(1'b1, 16'h0080, 1'b1, 1'b0);
    invalOnAck = 1'b1;
    ackSeen = 1'b0;
    for (int i = 0; i < 20 && !ackSeen; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
      ackSeen = memAck;
    end
    invalOnAck = 1'b0;
    checkOutput("inv_ack_seen", 32'(ackSeen), 32'd1);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("inv_ack_valid", 32'(insValid), 32'd0);
    checkOutput("inv_ack_pc", 32'(pcOut), 32'h0080);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("inv_ack_rereq", 32'(memReq), 32'd1);
    checkOutput("inv_ack_readdr", 32'(memAddr), 32'h0080);
    waitValid(20, 16'h0080);

    // Invalidate on a hit hides that hit, and the next lookup misses.
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b1);
    checkOutput("inv_hit_valid", 32'(insValid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("inv_hit_miss", 32'(insValid), 32'd0);
    waitValid(20, 16'h0080);

    // A stray ack with no request outstanding must not disturb the line.
    spuriousAck = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    spuriousAck = 1'b0;
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("stray_ack_valid", 32'(insValid), 32'd1);
    checkOutput("stray_ack_ins", 32'(ins), 32'(memWord(16'h0080)));

    // PC wrap from 0xFFFE to 0x0000.
    applyStimulus(1'b1, 16'hFFFE, 1'b1, 1'b0);
    waitValid(20, 16'hFFF8);
    checkOutput("wrap_pc", 32'(pcOut), 32'hFFFE);
    checkOutput("wrap_inc", 32'(pcInc), 32'h0000);
    pushExp(16'hFFFE);
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("wrap_next_pc", 32'(pcOut), 32'h0000);
    checkOutput("wrap_next_valid", 32'(insValid), 32'd0);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0);
    checkOutput("wrap_req", 32'(memReq), 32'd1);

    // Reset in the middle of a refill drops the request without a clock edge.
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", 32'(memReq), 32'd0);
    checkOutput("async_rst_addr", 32'(memAddr), 32'd0);
    checkOutput("async_rst_pc", 32'(pcOut), 32'(RESET_PC));

    checkOutput("sb_drained", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
